// File: rtl/lib_voq_buffer_pkg.sv
// Shared definitions for the virtual-output-queue buffer: width helper and VOQ index type.
package lib_voq_buffer_pkg;

  // Widest VOQ index supported; decoded grant indices are carried at this width.
  localparam int VOQ_IDX_MAX_W = 8;

  typedef logic [VOQ_IDX_MAX_W-1:0] voq_idx_t;

  // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit field.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lib_voq_fifo.sv
// Single virtual output queue: circular storage with read/write pointers and an occupancy count.
module lib_voq_fifo
  import lib_voq_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = clog2_safe(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == CW'(0));
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; the count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push_s && !reset) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/lib_voq_buffer.sv
// Input-side VOQ buffer: demuxes ingress into per-destination FIFOs and pops the granted head.
module lib_voq_buffer
  import lib_voq_buffer_pkg::*;
#(
  parameter int M     = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         i_data,
  input  logic [clog2_safe(M)-1:0] i_dest,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [0:M-1]             o_request,
  input  logic [0:M-1]             i_grant,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [clog2_safe(M)-1:0] o_dest,
  output logic                     o_error
);

  localparam int DW = clog2_safe(M);
  localparam int CW = clog2_safe(M + 1);

  logic [M-1:0]     push_s;
  logic [M-1:0]     pop_s;
  logic [M-1:0]     full_s;
  logic [M-1:0]     empty_s;
  logic [WIDTH-1:0] head_s [M];

  logic [CW-1:0]    gnt_cnt_s;
  voq_idx_t         gnt_idx_s;
  logic             sel_empty_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             pop_valid_s;
  logic             err_evt_s;

  logic [WIDTH-1:0] o_data_q, o_data_d;
  logic [DW-1:0]    o_dest_q, o_dest_d;
  logic             o_valid_q, o_valid_d;
  logic             o_error_q, o_error_d;

  for (genvar g = 0; g < M; g++) begin : g_voq
    lib_voq_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_s[g]),
      .pop_i   (pop_s[g]),
      .wdata_i (i_data),
      .rdata_o (head_s[g]),
      .full_o  (full_s[g]),
      .empty_o (empty_s[g])
    );
    assign o_request[g] = !empty_s[g];
  end

  // Ingress demux; o_ready only looks at the pre-edge full flag of the addressed queue.
  always_comb begin
    o_ready = 1'b0;
    push_s  = '0;
    for (int d = 0; d < M; d++) begin
      if (i_dest == DW'(d)) begin
        o_ready = !full_s[d];
      end else begin
        o_ready = o_ready;
      end
    end
    for (int d = 0; d < M; d++) begin
      push_s[d] = i_valid && o_ready && (i_dest == DW'(d));
    end
  end

  // Grant decode: only a one-hot grant of a non-empty queue pops; anything else is a protocol error.
  always_comb begin
    gnt_cnt_s   = '0;
    gnt_idx_s   = '0;
    sel_empty_s = 1'b1;
    sel_data_s  = '0;
    pop_s       = '0;
    for (int d = 0; d < M; d++) begin
      if (i_grant[d]) begin
        gnt_cnt_s = gnt_cnt_s + CW'(1);
        gnt_idx_s = voq_idx_t'(d);
      end else begin
        gnt_cnt_s = gnt_cnt_s;
      end
    end
    for (int d = 0; d < M; d++) begin
      if (gnt_idx_s == voq_idx_t'(d)) begin
        sel_empty_s = empty_s[d];
        sel_data_s  = head_s[d];
      end else begin
        sel_empty_s = sel_empty_s;
      end
    end
    pop_valid_s = (gnt_cnt_s == CW'(1)) && !sel_empty_s;
    err_evt_s   = (gnt_cnt_s > CW'(1)) || ((gnt_cnt_s == CW'(1)) && sel_empty_s);
    for (int d = 0; d < M; d++) begin
      pop_s[d] = pop_valid_s && i_grant[d];
    end
  end

  // Egress register next state; data and index hold when nothing is popped.
  always_comb begin
    o_valid_d = pop_valid_s;
    o_data_d  = o_data_q;
    o_dest_d  = o_dest_q;
    o_error_d = o_error_q || err_evt_s;
    if (pop_valid_s) begin
      o_data_d = sel_data_s;
      o_dest_d = gnt_idx_s[DW-1:0];
    end else begin
      o_data_d = o_data_q;
      o_dest_d = o_dest_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_data_q  <= '0;
      o_dest_q  <= '0;
      o_valid_q <= 1'b0;
      o_error_q <= 1'b0;
    end else begin
      o_data_q  <= o_data_d;
      o_dest_q  <= o_dest_d;
      o_valid_q <= o_valid_d;
      o_error_q <= o_error_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_dest  = o_dest_q;
  assign o_valid = o_valid_q;
  assign o_error = o_error_q;

endmodule

// File: tb/tb_lib_voq_buffer.sv
// Randomized scoreboard bench for lib_voq_buffer against a queue-based reference model.
module tb_lib_voq_buffer;

  localparam int M = 4;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] i_data = '0;
  logic [1:0]       i_dest = '0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [0:M-1]     o_request;
  logic [0:M-1]     i_grant = '0;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic [1:0]       o_dest;
  logic             o_error;

  lib_voq_buffer #(.M(M), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_dest(i_dest), .i_valid(i_valid),
    .o_ready(o_ready), .o_request(o_request), .i_grant(i_grant), .o_data(o_data),
    .o_valid(o_valid), .o_dest(o_dest), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] mq [M][$];
  logic [9:0]       exp_q [$];
  logic             model_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [0:M-1] model_req();
    logic [0:M-1] r;
    for (int d = 0; d < M; d++) r[d] = (mq[d].size() != 0);
    return r;
  endfunction

  // One clock of stimulus: drive, check pre-edge combinational outputs, advance the model at the edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] dat, input logic [1:0] dst,
                       input logic [0:M-1] gnt, input logic rst);
    int ones;
    int gd;
    logic acc;
    i_valid = v; i_data = dat; i_dest = dst; i_grant = gnt; reset = rst;
    #1;
    chk("o_ready", {31'b0, o_ready}, {31'b0, mq[dst].size() < DEPTH});
    chk("o_request", {28'b0, o_request}, {28'b0, model_req()});
    chk("o_error", {31'b0, o_error}, {31'b0, model_err});
    acc = v && (mq[dst].size() < DEPTH);
    @(posedge clk);
    if (rst) begin
      for (int d = 0; d < M; d++) mq[d].delete();
      model_err = 1'b0;
    end else begin
      ones = 0; gd = 0;
      for (int d = 0; d < M; d++) if (gnt[d]) begin ones++; gd = d; end
      if (ones == 1 && mq[gd].size() > 0) exp_q.push_back({gd[1:0], mq[gd].pop_front()});
      else if (ones != 0) model_err = 1'b1;
      if (acc) mq[dst].push_back(dat);
    end
    #1;
    if (rst) begin
      chk("rst_o_data", {24'b0, o_data}, 32'h0);
      chk("rst_o_dest", {30'b0, o_dest}, 32'h0);
    end
  endtask

  // Monitor: every output beat must match the oldest expected pop, and no beat may be missing.
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (!reset || exp_q.size() != 0) begin
        if (o_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_o_valid", 32'h1, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("o_data", {24'b0, o_data}, {24'b0, e[7:0]});
            chk("o_dest", {30'b0, o_dest}, {30'b0, e[9:8]});
          end
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("missing_o_valid", 32'h0, 32'h1);
        end
      end
    end
  end

  initial begin
    logic [0:M-1] g;
    logic [0:M-1] lit;
    int r;
    int d;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    // Basic push then pop of one entry.
    cycle(1'b1, 8'h11, 2'd2, 4'b0000, 1'b0);
    lit = 4'b0010;
    chk("req_after_push", {28'b0, o_request}, {28'b0, lit});
    cycle(1'b0, 8'h00, 2'd0, 4'b0010, 1'b0);
    chk("req_after_pop", {28'b0, o_request}, 32'h0);
    // Fill VOQ 1, attempt a fifth push, then drain in order.
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'hA0 + 8'(k), 2'd1, 4'b0000, 1'b0);
    chk("full_ready", {31'b0, o_ready}, 32'h0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 2'd1, 4'b0100, 1'b0);
    cycle(1'b0, 8'h00, 2'd1, 4'b0000, 1'b0);
    chk("drained_ready", {31'b0, o_ready}, 32'h1);
    // Same-VOQ push and pop together keep the count at two.
    cycle(1'b1, 8'h31, 2'd3, 4'b0000, 1'b0);
    cycle(1'b1, 8'h32, 2'd3, 4'b0000, 1'b0);
    cycle(1'b1, 8'h55, 2'd3, 4'b0001, 1'b0);
    chk("same_voq_count", {30'b0, 2'(mq[3].size())}, 32'h2);
    cycle(1'b0, 8'h00, 2'd3, 4'b0001, 1'b0);
    cycle(1'b0, 8'h00, 2'd3, 4'b0001, 1'b0);
    // Protocol errors: empty grant, then a two-hot grant.
    cycle(1'b0, 8'h00, 2'd0, 4'b1000, 1'b0);
    cycle(1'b1, 8'h61, 2'd1, 4'b0000, 1'b0);
    cycle(1'b1, 8'h62, 2'd2, 4'b0000, 1'b0);
    cycle(1'b0, 8'h00, 2'd0, 4'b0110, 1'b0);
    chk("err_sticky", {31'b0, o_error}, 32'h1);
    // Reset discards queued entries.
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'h70 + 8'(k), 2'd0, 4'b0000, 1'b0);
    cycle(1'b1, 8'h7F, 2'd0, 4'b1000, 1'b1);
    chk("post_rst_req", {28'b0, o_request}, 32'h0);
    chk("post_rst_err", {31'b0, o_error}, 32'h0);
    cycle(1'b0, 8'h00, 2'd0, 4'b1000, 1'b0);
    // Random mix, mostly legal grants with rare protocol errors and resets.
    for (int n = 0; n < 10000; n++) begin
      g = '0;
      r = $urandom_range(0, 999);
      d = $urandom_range(0, M - 1);
      if (r < 3) begin
        g[d] = 1'b1; g[(d + 1) % M] = 1'b1;
      end else if (r < 6) begin
        g[d] = 1'b1;
      end else if (r < 650 && mq[d].size() > 0) begin
        g[d] = 1'b1;
      end
      cycle($urandom_range(0, 99) < 60, 8'($urandom), 2'($urandom_range(0, M - 1)), g,
            $urandom_range(0, 1999) == 0);
    end
    cycle(1'b0, 8'h00, 2'd0, 4'b0000, 1'b0);
    #3;
    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lib_voq_buffer.md
LIB_VOQ_BUFFER -- requirements
Module: lib_voq_buffer

Interface
REQ-001 Parameter M, default 4: number of destinations (allocator resources); one virtual output queue (VOQ) per destination.
REQ-002 Parameter DEPTH, default 4: entries per VOQ, power of two, >=2.
REQ-003 Parameter WIDTH, default 8: payload bits per entry.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_data  input  WIDTH  ingress payload.
REQ-007 i_dest  input  $clog2(M)  destination index of i_data.
REQ-008 i_valid  input  1  ingress payload present.
REQ-009 o_ready  output  1  VOQ selected by i_dest can accept; combinational, = not full[i_dest].
REQ-010 o_request  output  M  [0:M-1] request vector to allocator; bit d = VOQ d non-empty.
REQ-011 i_grant  input  M  [0:M-1] grant from allocator for this input; at most one bit set.
REQ-012 o_data  output  WIDTH  egress payload (head of granted VOQ).
REQ-013 o_valid  output  1  o_data valid this cycle.
REQ-014 o_dest  output  $clog2(M)  VOQ index o_data was popped from.
REQ-015 o_error  output  1  sticky protocol error flag.

Function
REQ-016 Push: i_valid && o_ready at edge -> i_data written to tail of VOQ i_dest, its count +1.
REQ-017 i_valid && !o_ready -> no write, no state change; source holds data (valid/ready handshake).
REQ-018 o_request[d] = (count[d] != 0), driven combinationally from registered counts only, never from i_grant (no combinational loop through allocator).
REQ-019 Push at edge t -> o_request bit asserted from cycle t+1 (1-cycle latency).
REQ-020 Pop: i_grant one-hot with bit d set and count[d] != 0 at edge t -> head of VOQ d popped; o_data=head, o_dest=d, o_valid=1 registered, visible in cycle t+1 only.
REQ-021 No valid pop at edge t -> o_valid=0 in cycle t+1; o_data/o_dest hold previous values.
REQ-022 o_request reflects the pop in cycle t+1 (count decremented); a single-entry VOQ granted at t shows o_request[d]=0 at t+1.
REQ-023 Simultaneous push and pop, same VOQ: both performed, count unchanged, FIFO order preserved; push to a full VOQ refused even if popped same cycle (o_ready uses pre-edge full only).
REQ-024 Simultaneous push and pop, different VOQs: both performed independently.
REQ-025 Grant to empty VOQ: ignored (no pop, o_valid=0 next cycle), o_error set.
REQ-026 Grant with >1 bit set: no pop, o_error set.
REQ-027 o_error sticky until reset.
REQ-028 Read/write pointers log2(DEPTH) bits, wrap modulo DEPTH; count $clog2(DEPTH+1) bits, range 0..DEPTH, never over/underflows.
REQ-029 Entries leave each VOQ strictly in arrival order.

Reset
REQ-030 reset high at edge: all counts and pointers 0, o_valid=0, o_error=0, o_data=0, o_dest=0; hence o_request=0 and o_ready=1 in the following cycle.
REQ-031 Reset mid-operation discards all queued entries; pushes/grants coinciding with the reset edge are ignored.
REQ-032 Storage array contents need not be reset.

Structure
REQ-033 Shared LIB package holds a clog2-safe width constant helper and the VOQ index type; payload stays parameterised.
REQ-034 Single-VOQ FIFO (storage, pointers, count, full/empty) is one sub-module, lib_voq_fifo, instantiated M times via generate; top holds demux, grant decode, egress register, error logic.

Verification (M=4, DEPTH=4, WIDTH=8)
REQ-035 After reset push 0x11 dest 2 -> next cycle o_request=0010b; grant 0010b -> next cycle o_valid=1, o_data=0x11, o_dest=2, o_request=0000b.
REQ-036 Push 0xA0..0xA3 dest 1 -> o_ready=0 when i_dest=1; 5th push refused; four grants 0100b -> o_data 0xA0,0xA1,0xA2,0xA3 in order, o_ready=1 again.
REQ-037 VOQ 3 holding 2 entries, push 0x55 dest 3 plus grant 0001b same cycle -> count stays 2, oldest entry out, 0x55 at tail.
REQ-038 Grant 1000b with VOQ 0 empty -> o_valid=0 next cycle, o_error=1 and stays 1; grant 0110b with both non-empty -> no pop, o_error=1.
REQ-039 Fill VOQ 0 with 3 entries, assert reset one cycle -> o_request=0000b, o_ready=1, o_error=0; subsequent grant 1000b produces no o_valid.
REQ-040 Random push/grant mix over 10k cycles against scoreboard -> per-VOQ order preserved, no loss/duplication, o_request matches model counts every cycle.
